ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte to the mouse (e.g. reset 0xFF, enable reporting 0xF4, set sample rate 0xF3 plus argument).
- Opposite direction to the mouse packet receiver; shares the PS2Clk/PS2Data open-drain pins.
- Top level ties the `*_oe` outputs to IOBUF tristates and holds the receiver off while `tx_busy` is high.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and receive paths:
// FSM state encoding, mouse command/response bytes and cycle-count helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    localparam int         HZ_PER_MHZ   = 1_000_000;
    localparam logic [3:0] LAST_BIT     = 4'd9;

    function automatic int inhibit_cycles(input int clk_hz, input int us);
        return clk_hz / HZ_PER_MHZ * us;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS2Clk/PS2Data pads plus a clock falling-edge
// strobe; idle (released) lines read as 1, so the flops reset high.
module ps2_line_sync (
    input  logic clock,
    input  logic rst,
    input  logic clk_pad,
    input  logic data_pad,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Synchronise both pads and keep the previous clock sample for edge detection
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            data_meta <= 1'b1;
            clk_sync  <= 1'b1;
            data_sync <= 1'b1;
            clk_prev  <= 1'b1;
        end else begin
            clk_meta  <= clk_pad;
            data_meta <= data_pad;
            clk_sync  <= clk_meta;
            data_sync <= data_meta;
            clk_prev  <= clk_sync;
        end
    end

    assign fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain enables.
// Define PS2_TX_RETRY_EN to resend the latched frame on NACK/timeout up to MAX_RETRY times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int INHIBIT_US     = 100,
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INHIBIT_CYCLES = inhibit_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state;
    logic [9:0]       frame;
    logic [3:0]       bitcnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic clk_sync;
    logic data_sync;
    logic fall;
    logic watch;
    logic lines_idle;
    logic nack;
    logic timeout;
    logic retry_ok;
    logic restart;

    ps2_line_sync u_sync (
        .clock     (clock),
        .rst       (rst),
        .clk_pad   (ps2_clk_in),
        .data_pad  (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .fall      (fall)
    );

    assign tx_ready   = (state == IDLE);
    assign tx_busy    = (state != IDLE);
    assign watch      = (state == RTS) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign lines_idle = clk_sync & data_sync;
    assign nack       = (state == WAIT_IDLE) & lines_idle & ~ack_ok;
    // A device clock edge in the expiry cycle keeps the transaction alive
    assign timeout    = watch & ~fall & (to_cnt == TO_LAST);
    assign restart    = retry_ok & (timeout | nack);

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_cnt;

    assign retry_ok = (retry_cnt < RETRY_LIM);

    // Attempts used for the current byte; cleared when a new byte is accepted
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            retry_cnt <= {RETRY_W{1'b0}};
        end else if (tx_ready && tx_valid) begin
            retry_cnt <= {RETRY_W{1'b0}};
        end else if (restart) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign retry_ok = (MAX_RETRY < 0);
`endif

    // Timeout counter: reloaded by every device clock fall while the device owns the clock
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            to_cnt <= {TO_W{1'b0}};
        end else if (fall || !watch) begin
            to_cnt <= {TO_W{1'b0}};
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Transaction FSM with registered pad enables and status pulses
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frame       <= 10'h000;
            bitcnt      <= 4'd0;
            inh_cnt     <= {INH_W{1'b0}};
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame       <= {1'b1, odd_parity(tx_data), tx_data};
                        bitcnt      <= 4'd0;
                        inh_cnt     <= {INH_W{1'b0}};
                        ack_ok      <= 1'b0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                RTS, SEND: begin
                    if (fall) begin
                        ps2_data_oe <= ~frame[bitcnt];
                        bitcnt      <= bitcnt + 4'd1;
                        state       <= (bitcnt == LAST_BIT) ? ACK : SEND;
                    end
                end
                ACK: begin
                    if (fall) begin
                        ack_ok <= ~data_sync;
                        state  <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (lines_idle) begin
                        if (restart) begin
                            bitcnt     <= 4'd0;
                            inh_cnt    <= {INH_W{1'b0}};
                            ps2_clk_oe <= 1'b1;
                            state      <= INHIBIT;
                        end else begin
                            done  <= 1'b1;
                            err   <= ~ack_ok;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase

            if (timeout) begin
                ps2_data_oe <= 1'b0;
                ack_ok      <= 1'b0;
                if (restart) begin
                    bitcnt     <= 4'd0;
                    inh_cnt    <= {INH_W{1'b0}};
                    ps2_clk_oe <= 1'b1;
                    state      <= INHIBIT;
                end else begin
                    ps2_clk_oe <= 1'b0;
                    done       <= 1'b1;
                    err        <= 1'b1;
                    state      <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus with a behavioural mouse that
// clocks frames, samples bits on rising edges and answers ACK/NACK/silence.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int INH_US = 20;
    localparam int INH    = 20;
    localparam int TO     = 400;
    localparam int HALF   = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int EXP_FRAMES = 3;
`else
    localparam int EXP_FRAMES = 1;
`endif

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, done, ack_ok, err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int stray_err = 0;
    int last_fall_cyc = 0;
    logic last_err = 1'b0;
    logic last_ack = 1'b0;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .INHIBIT_US     (INH_US),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (2)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_err <= err;
            last_ack <= ack_ok;
        end
        if (err && !done) stray_err <= stray_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, input string tag);
        int n;
        n = 0;
        while (done_cnt == base && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk(tag, done_cnt - base, 1);
    endtask

    // ack_mode: 0 = ACK, 1 = NACK, 2 = no response
    task automatic dev_frame(input int falls, input int ack_mode,
                             output logic [9:0] bits, output int low);
        int n;
        bits = 10'h000;
        low  = 0;
        n    = 0;
        while (!ps2_clk_oe && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("inhibit_seen", ps2_clk_oe, 1);
        while (ps2_clk_oe && low < 5000) begin
            low++;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        chk("start_bit", data_line, 0);
        for (int k = 0; k < falls; k++) begin
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clock);
            bits[k] = data_line;
            repeat (HALF / 2) @(negedge clock);
        end
        if (falls == 10 && ack_mode != 2) begin
            dev_data_low = (ack_mode == 0);
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clock);
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        int low, base, frames, n;
        logic busy_seen;

        repeat (3) @(negedge clock);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // 0xF4: 5 ones -> parity 0
        base = done_cnt;
        send_byte(CMD_ENABLE);
        chk("f4_ready_drop", tx_ready, 0);
        chk("f4_busy", tx_busy, 1);
        dev_frame(10, 0, bits, low);
        chk("f4_inhibit_len", (low >= INH) && (low <= INH + 1), 1);
        chk("f4_data", bits[7:0], 8'hF4);
        chk("f4_parity", bits[8], 0);
        chk("f4_stop", bits[9], 1);
        wait_done(base, 100, "f4_done");
        chk("f4_ack_ok", last_ack, 1);
        chk("f4_err", last_err, 0);
        @(negedge clock);
        chk("f4_ready_back", tx_ready, 1);
        chk("f4_busy_clear", tx_busy, 0);

        // 0xFF: 8 ones -> parity 1
        base = done_cnt;
        send_byte(CMD_RESET);
        dev_frame(10, 0, bits, low);
        chk("ff_data", bits[7:0], 8'hFF);
        chk("ff_parity", bits[8], 1);
        wait_done(base, 100, "ff_done");
        chk("ff_ack_ok", last_ack, 1);

        // 0xF3 NACKed: 6 ones -> parity 1
        base   = done_cnt;
        frames = 0;
        send_byte(CMD_SET_RATE);
        for (int a = 0; a < 4; a++) begin
            dev_frame(10, 1, bits, low);
            frames++;
            n = 0;
            while (done_cnt == base && !ps2_clk_oe && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (done_cnt != base) break;
        end
        chk("nack_frames", frames, EXP_FRAMES);
        chk("nack_data", bits[7:0], 8'hF3);
        chk("nack_parity", bits[8], 1);
        chk("nack_done", done_cnt - base, 1);
        chk("nack_err", last_err, 1);
        chk("nack_ack_ok", last_ack, 0);

        // Device stops clocking after 4 bits of 0x55
        base = done_cnt;
        send_byte(8'h55);
        dev_frame(4, 2, bits, low);
        wait_done(base, TO + 100, "to_done");
        chk("to_latency", (done_cyc - last_fall_cyc >= TO) && (done_cyc - last_fall_cyc <= TO + 8), 1);
        chk("to_err", last_err, 1);
        chk("to_ack_ok", last_ack, 0);
        @(negedge clock);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        chk("to_ready", tx_ready, 1);

        // Asynchronous reset while bit 5 (0) of 0x55 is on the wire
        base = done_cnt;
        send_byte(8'h55);
        dev_frame(6, 2, bits, low);
        chk("rst_mid_bits", bits[5:0], 6'h15);
        @(negedge clock);
        chk("pre_rst_data_oe", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_clk_oe", ps2_clk_oe, 0);
        chk("async_data_oe", ps2_data_oe, 0);
        chk("async_busy", tx_busy, 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (30) @(negedge clock);
        chk("rst_no_done", done_cnt - base, 0);
        chk("rst_ready", tx_ready, 1);

        // Second request during INHIBIT must be dropped: 0x12 has 2 ones -> parity 1
        base = done_cnt;
        send_byte(8'h12);
        repeat (3) @(negedge clock);
        tx_data  = CMD_SET_RATE;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        dev_frame(10, 0, bits, low);
        chk("ign_data", bits[7:0], 8'h12);
        chk("ign_parity", bits[8], 1);
        chk("ign_stop", bits[9], 1);
        wait_done(base, 100, "ign_done");
        chk("ign_ack_ok", last_ack, 1);
        busy_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (ps2_clk_oe || tx_busy) busy_seen = 1'b1;
        end
        chk("ign_no_second", busy_seen, 0);
        chk("ign_single_done", done_cnt - base, 1);

        chk("err_only_with_done", stray_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
